// File: rtl/lc_ctrl_signal_seq_if.sv
// lc_ctrl_signal_seq_if: FSM-side inputs and broadcast outputs of the life cycle sequencer
interface lc_ctrl_signal_seq_if #(
  parameter int NumSig   = 12,
  parameter int GrpW     = 3,
  parameter int DivWidth = 128
);
  logic                     bcast_en_i;
  logic                     post_trans_i;
  logic                     lc_grp_valid_i;
  logic [GrpW-1:0]          lc_grp_i;
  logic [3:0]               secrets_valid_i;
  logic [3:0]               esc_req_i;
  logic [NumSig-1:0][3:0]   lc_en_o;
  logic [3:0]               lc_escalate_en_o;
  logic [DivWidth-1:0]      lc_keymgr_div_o;
  logic                     ramp_done_o;
  modport master (
    output bcast_en_i, post_trans_i, lc_grp_valid_i, lc_grp_i, secrets_valid_i, esc_req_i,
    input  lc_en_o, lc_escalate_en_o, lc_keymgr_div_o, ramp_done_o
  );
  modport slave (
    input  bcast_en_i, post_trans_i, lc_grp_valid_i, lc_grp_i, secrets_valid_i, esc_req_i,
    output lc_en_o, lc_escalate_en_o, lc_keymgr_div_o, ramp_done_o
  );
endinterface

// File: rtl/lc_ctrl_signal_seq.sv
// lc_ctrl_signal_seq: filters the life cycle group, then ramps lc_tx_t enables one channel per step
module lc_ctrl_signal_seq #(
  parameter int NumSig    = 12,
  parameter int NumGroups = 6,
  parameter int GrpW      = $clog2(NumGroups),
  parameter logic [NumGroups-1:0][NumSig-1:0] EnTable = '0,
  parameter logic [NumSig-1:0] SecretsOnMask  = '0,
  parameter logic [NumSig-1:0] SecretsOffMask = '0,
  parameter int DivWidth  = 128,
  parameter logic [NumGroups-1:0][DivWidth-1:0] DivTable =
    {DivWidth'(6), DivWidth'(5), DivWidth'(4), DivWidth'(3), DivWidth'(2), DivWidth'(1)},
  parameter logic [DivWidth-1:0] DivInvalid = '0,
  parameter int StableCycles = 4,
  parameter int StepCycles   = 2
) (
  input logic clk_i,
  input logic rst_i,
  lc_ctrl_signal_seq_if.slave bus
);
  localparam logic [3:0] LcOn  = 4'b0101;
  localparam logic [3:0] LcOff = 4'b1010;
  localparam int CntW  = $clog2(StableCycles + 1);
  localparam int IdxW  = NumSig > 1 ? $clog2(NumSig) : 1;
  localparam int StepW = $clog2(StepCycles + 1);
  localparam bit Stable1 = StableCycles == 1;
  typedef enum logic [2:0] {ResetSt, FilterSt, RampSt, SteadySt, PostSt, EscSt} state_e;
  state_e state_q, state_d;
  logic [NumSig-1:0] tgt, tgt_q, tgt_d, en_q, en_d;
  logic [GrpW-1:0] grp_q, grp_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [StepW-1:0] step_q, step_d;
  logic [DivWidth-1:0] div_q, div_d;
  logic grp_ok, sec_on, esc_trig;
  assign grp_ok   = 32'(bus.lc_grp_i) < NumGroups;
  assign sec_on   = bus.secrets_valid_i == LcOn;
  // A channel in both masks needs secrets both On and not On, so it never turns On.
  assign tgt      = (grp_ok ? EnTable[bus.lc_grp_i] : '0)
                  & ~(SecretsOnMask & {NumSig{!sec_on}}) & ~(SecretsOffMask & {NumSig{sec_on}});
  assign esc_trig = bus.esc_req_i != LcOff || (bus.bcast_en_i && (!bus.lc_grp_valid_i || !grp_ok));
  assign cnt_inc  = cnt_q + CntW'(1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ResetSt;
      tgt_q   <= '0;
      grp_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      en_q    <= '0;
      div_q   <= DivInvalid;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      en_q    <= en_d;
      div_q   <= div_d;
    end
  end
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    step_d  = step_q;
    en_d    = '0;
    div_d   = DivInvalid;
    if (state_q == EscSt || esc_trig) state_d = EscSt;
    else if (state_q == PostSt || bus.post_trans_i) state_d = PostSt;
    else if (!bus.bcast_en_i) state_d = ResetSt;
    else if (state_q == ResetSt || tgt != tgt_q) begin
      // Any target change drops the outputs and restarts filtering with this cycle counted.
      state_d = Stable1 ? RampSt : FilterSt;
      tgt_d   = tgt;
      grp_d   = bus.lc_grp_i;
      cnt_d   = CntW'(1);
      idx_d   = '0;
      step_d  = '0;
    end else if (state_q == FilterSt) begin
      cnt_d   = cnt_inc;
      state_d = cnt_inc >= CntW'(StableCycles) ? RampSt : FilterSt;
    end else begin
      en_d  = en_q;
      div_d = div_q;
      if (state_q == RampSt) begin
        if (step_q == '0) begin
          en_d[idx_q] = tgt_q[idx_q];
          div_d       = idx_q == '0 ? DivTable[grp_q] : div_q;
          step_d      = StepW'(StepCycles - 1);
          idx_d       = idx_q + IdxW'(1);
          state_d     = idx_q == IdxW'(NumSig - 1) ? SteadySt : RampSt;
        end else step_d = step_q - StepW'(1);
      end
    end
  end
  always_comb begin
    for (int i = 0; i < NumSig; i++) bus.lc_en_o[i] = en_q[i] ? LcOn : LcOff;
    bus.lc_escalate_en_o = state_q == EscSt ? LcOn : LcOff;
    bus.lc_keymgr_div_o  = div_q;
    bus.ramp_done_o      = state_q == SteadySt;
  end
endmodule
